mano_program_loader: RTL and testbench



---
 rtl/mano_pkg.sv | 33 +++
 rtl/mano_program_loader_if.sv | 26 ++
 rtl/mano_loader_csum.sv | 31 +++
 rtl/mano_program_loader.sv | 208 ++++++++++++++++++++
 tb/tb_mano_program_loader.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mano_pkg.sv
// Shared types and constants for the Mano CPU program loader.
// Field order on the host link is big-endian: high byte of every multi-byte field first.
package mano_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         ADDR_W            = 12;
    localparam int         WORD_W            = 16;
    localparam int         BYTE_W            = 8;

    // Bit position where the first-received (high) byte lands in a 16-bit field.
    localparam int         FIELD_HI_LSB      = 8;
    // ADDR_HI carries only the top address bits in its low nibble.
    localparam int         ADDR_HI_BITS      = ADDR_W - BYTE_W;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ADDR_HI = 4'd1,
        ST_ADDR_LO = 4'd2,
        ST_CNT_HI  = 4'd3,
        ST_CNT_LO  = 4'd4,
        ST_DATA_HI = 4'd5,
        ST_DATA_LO = 4'd6,
        ST_CHECK   = 4'd7,
        ST_RUN     = 4'd8,
        ST_ERROR   = 4'd9
    } loader_state_e;

    function automatic logic [WORD_W-1:0] join_be(input logic [BYTE_W-1:0] hi,
                                                  input logic [BYTE_W-1:0] lo);
        return (WORD_W'(hi) << FIELD_HI_LSB) | WORD_W'(lo);
    endfunction

endpackage

// File: rtl/mano_program_loader_if.sv
// Host byte stream plus Mano CPU program-load port, bundled for the loader.
interface mano_program_loader_if;

    logic                        host_valid;
    logic [7:0]                  host_data;
    logic                        host_ready;
    logic [mano_pkg::ADDR_W-1:0] address;
    logic [mano_pkg::WORD_W-1:0] code;
    logic                        run_code;
    logic                        load_busy;
    logic                        load_done;
    logic                        load_error;

    // The loader consumes host bytes and drives the CPU load port.
    modport slave (
        input  host_valid, host_data,
        output host_ready, address, code, run_code, load_busy, load_done, load_error
    );

    // Host / CPU side as seen from outside the loader.
    modport master (
        output host_valid, host_data,
        input  host_ready, address, code, run_code, load_busy, load_done, load_error
    );

endinterface

// File: rtl/mano_loader_csum.sv
// 8-bit running-sum accumulator for frame checksums. is_zero reports whether the
// sum would be zero after adding the byte currently on data (used on the CHK byte).
module mano_loader_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] data,
    output logic       is_zero
);

    logic [7:0] sum_r;
    logic [7:0] sum_with_data_s;

    assign sum_with_data_s = sum_r + data;
    assign is_zero         = (sum_with_data_s == 8'd0);

    // Accumulator register: clear wins over add.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= 8'd0;
        end else if (clear) begin
            sum_r <= 8'd0;
        end else if (add) begin
            sum_r <= sum_with_data_s;
        end else begin
            sum_r <= sum_r;
        end
    end

endmodule

// File: rtl/mano_program_loader.sv
// Mano CPU program loader: parses framed host bytes, writes words into CPU memory
// with run_code low, then releases the CPU. Build option: LOADER_CHECKSUM_EN enables the CHK byte.
module mano_program_loader
    import mano_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    mano_program_loader_if.slave   bus
);

    loader_state_e       state_r,  state_s;
    logic [ADDR_W-1:0]   ptr_r,    ptr_s;
    logic [WORD_W-1:0]   cnt_r,    cnt_s;
    logic [BYTE_W-1:0]   hi_r,     hi_s;
    logic [ADDR_W-1:0]   address_r, address_s;
    logic [WORD_W-1:0]   code_r,   code_s;
    logic                run_code_r, run_code_s;
    logic                busy_r,   busy_s;
    logic                done_r,   done_s;
    logic                ready_r;
    logic                accept_s;
    logic                sync_hit_s;
    logic [BYTE_W-1:0]   byte_s;
    logic [WORD_W-1:0]   cnt_lo_s;

    assign accept_s   = bus.host_valid && ready_r;
    assign byte_s     = bus.host_data;
    assign sync_hit_s = accept_s && (byte_s == SYNC_BYTE) &&
                        ((state_r == ST_IDLE) || (state_r == ST_RUN) || (state_r == ST_ERROR));
    assign cnt_lo_s   = {cnt_r[WORD_W-1:FIELD_HI_LSB], byte_s};

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e ST_AFTER_DATA = ST_CHECK;

    logic error_r, error_s;
    logic csum_add_s;
    logic csum_zero_s;

    // Every byte after SYNC, CHK included, feeds the sum.
    assign csum_add_s = accept_s && (state_r != ST_IDLE) && (state_r != ST_RUN) &&
                        (state_r != ST_ERROR);

    mano_loader_csum u_csum (
        .clk     (clk),
        .rst     (rst),
        .clear   (sync_hit_s),
        .add     (csum_add_s),
        .data    (byte_s),
        .is_zero (csum_zero_s)
    );

    assign bus.load_error = error_r;
`else
    localparam loader_state_e ST_AFTER_DATA = ST_RUN;

    assign bus.load_error = 1'b0;
`endif

    // Next-state, datapath and status-flag logic.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        cnt_s      = cnt_r;
        hi_s       = hi_r;
        address_s  = address_r;
        code_s     = code_r;
        run_code_s = run_code_r;
        busy_s     = busy_r;
        done_s     = done_r;
`ifdef LOADER_CHECKSUM_EN
        error_s    = error_r;
`endif

        if (accept_s) begin
            case (state_r)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    if (sync_hit_s) begin
                        state_s = ST_ADDR_HI;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_ADDR_HI: begin
                    ptr_s   = {byte_s[ADDR_HI_BITS-1:0], ptr_r[BYTE_W-1:0]};
                    state_s = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    ptr_s   = {ptr_r[ADDR_W-1:BYTE_W], byte_s};
                    state_s = ST_CNT_HI;
                end
                ST_CNT_HI: begin
                    cnt_s   = {byte_s, cnt_r[FIELD_HI_LSB-1:0]};
                    state_s = ST_CNT_LO;
                end
                ST_CNT_LO: begin
                    cnt_s = cnt_lo_s;
                    if (cnt_lo_s == 16'd0) begin
                        state_s = ST_AFTER_DATA;
                    end else begin
                        state_s = ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    hi_s    = byte_s;
                    state_s = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    code_s    = join_be(hi_r, byte_s);
                    address_s = ptr_r;
                    ptr_s     = ptr_r + 12'd1;
                    cnt_s     = cnt_r - 16'd1;
                    if (cnt_r == 16'd1) begin
                        state_s = ST_AFTER_DATA;
                    end else begin
                        state_s = ST_DATA_HI;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (csum_zero_s) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_ERROR;
                    end
                end
`endif
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        // Status flags change only on entry into a new state.
        if (state_s != state_r) begin
            case (state_s)
                ST_ADDR_HI: begin
                    run_code_s = 1'b0;
                    done_s     = 1'b0;
                    busy_s     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    error_s    = 1'b0;
`endif
                end
                ST_RUN: begin
                    run_code_s = 1'b1;
                    done_s     = 1'b1;
                    busy_s     = 1'b0;
                end
`ifdef LOADER_CHECKSUM_EN
                ST_ERROR: begin
                    error_s    = 1'b1;
                    busy_s     = 1'b0;
                end
`endif
                default: begin
                    busy_s = busy_r;
                end
            endcase
        end else begin
            busy_s = busy_r;
        end
    end

    // State and output registers; host_ready stays low for one cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 12'd0;
            cnt_r      <= 16'd0;
            hi_r       <= 8'd0;
            address_r  <= 12'd0;
            code_r     <= 16'd0;
            run_code_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ready_r    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            error_r    <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            cnt_r      <= cnt_s;
            hi_r       <= hi_s;
            address_r  <= address_s;
            code_r     <= code_s;
            run_code_r <= run_code_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            ready_r    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            error_r    <= error_s;
`endif
        end
    end

    assign bus.host_ready = ready_r;
    assign bus.address    = address_r;
    assign bus.code       = code_r;
    assign bus.run_code   = run_code_r;
    assign bus.load_busy  = busy_r;
    assign bus.load_done  = done_r;

endmodule

// File: tb/tb_mano_program_loader.sv
// Self-checking bench for mano_program_loader: framed byte streams with random gaps,
// checked against a frame-level model of expected CPU writes and status flags.
module tb_mano_program_loader;
    import mano_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mano_program_loader_if bus ();

    mano_program_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [11:0] exp_addr = 12'd0;
    logic [15:0] exp_code = 16'd0;
    logic [15:0] words_q[$];

    // Present one byte (after 0-2 idle cycles) and return at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.host_valid = 1'b1;
        bus.host_data  = b;
        n = 0;
        while (bus.host_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; failures++;
            $display("FAIL send_byte_timeout actual host_ready=%b required=1", bus.host_ready);
        end
        @(negedge clk);
        bus.host_valid = 1'b0;
    endtask

    // Send a frame built from words_q; model expected writes and checksum arithmetically.
    task automatic send_frame(input logic [11:0] start, input logic [3:0] junk_nib,
                              input bit skip_sync, input bit corrupt, output bit ok);
        int          sum;
        int          n;
        logic [15:0] cnt;
        logic [7:0]  hdr [4];
        logic [7:0]  chk;
        n   = words_q.size();
        cnt = 16'(n);
        hdr = '{{junk_nib, start[11:8]}, start[7:0], cnt[15:8], cnt[7:0]};
        if (!skip_sync) begin
            send_byte(8'hA5);
            checks++;
            if ({bus.load_busy, bus.run_code, bus.load_done} !== 3'b100) begin
                failures++;
                $display("FAIL sync_flags actual busy/run/done=%b required=100",
                         {bus.load_busy, bus.run_code, bus.load_done});
            end
        end
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            send_byte(hdr[i]);
            sum += int'(hdr[i]);
        end
        for (int k = 0; k < n; k++) begin
            send_byte(words_q[k][15:8]);
            send_byte(words_q[k][7:0]);
            sum += int'(words_q[k][15:8]) + int'(words_q[k][7:0]);
            exp_addr = 12'((int'(start) + k) % 4096);
            exp_code = words_q[k];
            checks++;
            if (bus.address !== exp_addr || bus.code !== exp_code) begin
                failures++;
                $display("FAIL word_write[%0d] actual addr=%h code=%h required addr=%h code=%h",
                         k, bus.address, bus.code, exp_addr, exp_code);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        chk = 8'((256 - (sum % 256)) % 256);
        if (corrupt) chk = chk + 8'd1;
        send_byte(chk);
`else
        chk = 8'(sum);
`endif
        ok = !corrupt;
    endtask

    task automatic check_outcome(input bit ok, input string name);
        logic [3:0] got;
        logic [3:0] want;
        got  = {bus.run_code, bus.load_done, bus.load_busy, bus.load_error};
        want = ok ? 4'b1100 : 4'b0001;
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s_flags actual run/done/busy/err=%b required=%b", name, got, want);
        end
        checks++;
        if (bus.address !== exp_addr || bus.code !== exp_code) begin
            failures++;
            $display("FAIL %s_held actual addr=%h code=%h required addr=%h code=%h",
                     name, bus.address, bus.code, exp_addr, exp_code);
        end
    endtask

    task automatic test_reset();
        bus.host_valid = 1'b0;
        bus.host_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.address, bus.code, bus.run_code, bus.host_ready, bus.load_busy,
             bus.load_done, bus.load_error} !== 33'd0) begin
            failures++;
            $display("FAIL reset_values actual addr=%h code=%h run=%b rdy=%b busy=%b done=%b err=%b required all 0",
                     bus.address, bus.code, bus.run_code, bus.host_ready, bus.load_busy,
                     bus.load_done, bus.load_error);
        end
        // A SYNC offered in the first cycle after reset must be ignored.
        rst = 1'b0;
        bus.host_valid = 1'b1;
        bus.host_data  = 8'hA5;
        @(negedge clk);
        bus.host_valid = 1'b0;
        checks++;
        if (bus.load_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_cycle_accept actual load_busy=%b required=0", bus.load_busy);
        end
        checks++;
        if (bus.host_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset actual=%b required=1", bus.host_ready);
        end
        exp_addr = 12'd0;
        exp_code = 16'd0;
    endtask

    task automatic test_plan_frame();
        bit ok;
        words_q = '{16'h7800, 16'h7001};
        send_frame(12'h100, 4'h0, 1'b0, 1'b0, ok);
        check_outcome(ok, "plan_frame");
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        bit ok;
        words_q = '{16'h7800, 16'h7001};
        send_frame(12'h100, 4'h0, 1'b0, 1'b1, ok);
        check_outcome(ok, "bad_checksum");
    endtask
`endif

    task automatic test_wrap();
        bit ok;
        words_q = '{16'h1111, 16'h2222};
        send_frame(12'hFFF, 4'h0, 1'b0, 1'b0, ok);
        check_outcome(ok, "wrap");
    endtask

    task automatic test_reset_midframe();
        bit ok;
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hAB);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.address, bus.code, bus.run_code, bus.host_ready, bus.load_busy,
             bus.load_done, bus.load_error} !== 33'd0) begin
            failures++;
            $display("FAIL midframe_reset actual addr=%h code=%h run=%b rdy=%b busy=%b done=%b err=%b required all 0",
                     bus.address, bus.code, bus.run_code, bus.host_ready, bus.load_busy,
                     bus.load_done, bus.load_error);
        end
        rst = 1'b0;
        @(negedge clk);
        exp_addr = 12'd0;
        exp_code = 16'd0;
        words_q = '{16'h0123, 16'h4567, 16'h89AB};
        send_frame(12'h340, 4'h0, 1'b0, 1'b0, ok);
        check_outcome(ok, "after_reset_frame");
    endtask

    task automatic test_run_ignore();
        bit ok;
        send_byte(8'h3C);
        checks++;
        if ({bus.run_code, bus.load_done, bus.load_busy} !== 3'b110) begin
            failures++;
            $display("FAIL run_ignore actual run/done/busy=%b required=110",
                     {bus.run_code, bus.load_done, bus.load_busy});
        end
        send_byte(8'hA5);
        checks++;
        if ({bus.run_code, bus.load_done, bus.load_busy} !== 3'b001) begin
            failures++;
            $display("FAIL run_resync actual run/done/busy=%b required=001",
                     {bus.run_code, bus.load_done, bus.load_busy});
        end
        words_q = '{16'hA5A5};
        send_frame(12'h7A5, 4'h0, 1'b1, 1'b0, ok);
        check_outcome(ok, "resync_frame");
    endtask

    task automatic test_cnt_zero();
        bit ok;
        words_q = {};
        send_frame(12'h200, 4'h0, 1'b0, 1'b0, ok);
        check_outcome(ok, "cnt_zero");
    endtask

    task automatic test_back_to_back();
        bit          ok;
        bit          corrupt;
        logic [7:0]  junk;
        int          n;
        for (int f = 0; f < 12; f++) begin
            repeat ($urandom_range(0, 3)) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h3C;
                send_byte(junk);
            end
            n = $urandom_range(0, 5);
            words_q = {};
            for (int k = 0; k < n; k++) words_q.push_back(16'($urandom));
            corrupt = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            corrupt = ($urandom_range(0, 3) == 0);
`endif
            send_frame(12'($urandom), 4'($urandom), 1'b0, corrupt, ok);
            check_outcome(ok, "random_frame");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.host_valid = 1'b0;
        bus.host_data  = 8'h00;
        test_reset();
        test_plan_frame();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_wrap();
        test_reset_midframe();
        test_run_ignore();
        test_cnt_zero();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
